// File: rtl/lsu_pkg.sv
// Shared types and funct3 width/sign codes for the load/store writeback unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WB,
      S_FLT
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/lsu_wb_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface lsu_wb_if #(
   parameter int width = 32
);
   logic             mem_req;
   logic             mem_we;
   logic [width-1:0] mem_addr;
   logic [3:0]       mem_be;
   logic [width-1:0] mem_wdata;
   logic             mem_gnt;
   logic             mem_rvalid;
   logic [width-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check, store byte enables and
// lane replication, and load byte/halfword extraction with sign handling.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int width = 32
) (
   input  logic             is_load,
   input  logic             is_store,
   input  logic [2:0]       funct3,
   input  logic [1:0]       offset,
   input  logic [width-1:0] sdata,
   input  logic [width-1:0] rdata,
   output logic [3:0]       be,
   output logic [width-1:0] wdata,
   output logic [width-1:0] ldata,
   output logic             bad
);
   logic [width-1:0] byte_rep;
   logic [width-1:0] half_rep;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;

   genvar gi;
   generate
      for (gi = 0; gi < width / 8; gi++) begin : g_byte_rep
         assign byte_rep[gi*8 +: 8] = sdata[7:0];
      end
      for (gi = 0; gi < width / 16; gi++) begin : g_half_rep
         assign half_rep[gi*16 +: 16] = sdata[15:0];
      end
   endgenerate

   assign ld_byte = rdata[{offset, 3'b000} +: 8];
   assign ld_half = rdata[{offset[1], 4'b0000} +: 16];

   // Unsigned widths exist only for loads; stores accept B/H/W only.
   always_comb begin
      bad = 1'b0;
      if (is_load == is_store) begin
         bad = 1'b1;
      end else begin
         case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = !is_load;
            F3_H:    bad = offset[0];
            F3_HU:   bad = !is_load || offset[0];
            F3_W:    bad = |offset;
            default: bad = 1'b1;
         endcase
      end
   end

   always_comb begin
      be    = 4'hF;
      wdata = sdata;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << offset;
            wdata = byte_rep;
         end
         2'b01: begin
            be    = 4'b0011 << {offset[1], 1'b0};
            wdata = half_rep;
         end
         default: begin
            be    = 4'hF;
            wdata = sdata;
         end
      endcase
   end

   always_comb begin
      ldata = rdata;
      case (funct3)
         F3_B:    ldata = {{(width-8){ld_byte[7]}}, ld_byte};
         F3_BU:   ldata = {{(width-8){1'b0}}, ld_byte};
         F3_H:    ldata = {{(width-16){ld_half[15]}}, ld_half};
         F3_HU:   ldata = {{(width-16){1'b0}}, ld_half};
         default: ldata = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_wb.sv
// Load/store FSM: captures one operation, runs the memory handshake and issues
// a one-cycle register-file write for loads. All outputs are registered.
module lsu_wb
   import lsu_pkg::*;
#(
   parameter int width = 32,
   parameter int dpath = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic             op_load,
   input  logic             op_store,
   input  logic [2:0]       funct3,
   input  logic [width-1:0] addr,
   input  logic [width-1:0] sdata,
   input  logic [dpath-1:0] rd,
   lsu_wb_if.master         mem,
   output logic [width-1:0] dataW,
   output logic [dpath-1:0] rsW,
   output logic             RegWen,
   output logic             busy,
   output logic             fault
);
   lsu_state_e       state_reg;
   logic             is_load_reg;
   logic             is_store_reg;
   logic [2:0]       funct3_reg;
   logic [1:0]       offset_reg;
   logic [dpath-1:0] rd_reg;
   logic             mem_req_reg;
   logic             mem_we_reg;
   logic [width-1:0] mem_addr_reg;
   logic [3:0]       mem_be_reg;
   logic [width-1:0] mem_wdata_reg;
   logic [width-1:0] data_reg;
   logic             reg_wen_reg;
   logic             busy_reg;
   logic             op_ready_reg;
   logic             fault_reg;

   logic             sel_load;
   logic             sel_store;
   logic [2:0]       sel_funct3;
   logic [1:0]       sel_offset;
   logic [3:0]       be;
   logic [width-1:0] wdata;
   logic [width-1:0] ldata;
   logic             bad;

   // One aligner serves both phases: live inputs in IDLE, captured op afterwards.
   assign sel_load   = (state_reg == S_IDLE) ? op_load   : is_load_reg;
   assign sel_store  = (state_reg == S_IDLE) ? op_store  : is_store_reg;
   assign sel_funct3 = (state_reg == S_IDLE) ? funct3    : funct3_reg;
   assign sel_offset = (state_reg == S_IDLE) ? addr[1:0] : offset_reg;

   lsu_align #(.width(width)) u_align (
      .is_load  (sel_load),
      .is_store (sel_store),
      .funct3   (sel_funct3),
      .offset   (sel_offset),
      .sdata    (sdata),
      .rdata    (mem.mem_rdata),
      .be       (be),
      .wdata    (wdata),
      .ldata    (ldata),
      .bad      (bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         is_load_reg   <= 1'b0;
         is_store_reg  <= 1'b0;
         funct3_reg    <= 3'd0;
         offset_reg    <= 2'd0;
         rd_reg        <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_be_reg    <= 4'h0;
         mem_wdata_reg <= '0;
         data_reg      <= '0;
         reg_wen_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         op_ready_reg  <= 1'b1;
         fault_reg     <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (op_valid) begin
                  is_load_reg  <= op_load;
                  is_store_reg <= op_store;
                  funct3_reg   <= funct3;
                  offset_reg   <= addr[1:0];
                  rd_reg       <= rd;
                  busy_reg     <= 1'b1;
                  op_ready_reg <= 1'b0;
                  if (bad) begin
                     state_reg <= S_FLT;
                     fault_reg <= 1'b1;
                  end else begin
                     state_reg     <= S_REQ;
                     mem_req_reg   <= 1'b1;
                     mem_we_reg    <= op_store;
                     mem_addr_reg  <= {addr[width-1:2], 2'b00};
                     mem_be_reg    <= be;
                     mem_wdata_reg <= wdata;
                  end
               end
            end
            S_REQ: begin
               if (mem.mem_gnt) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  if (is_load_reg) begin
                     state_reg <= S_WAIT;
                  end else begin
                     state_reg    <= S_IDLE;
                     busy_reg     <= 1'b0;
                     op_ready_reg <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (mem.mem_rvalid) begin
                  data_reg    <= ldata;
                  reg_wen_reg <= (rd_reg != '0);
                  state_reg   <= S_WB;
               end
            end
            S_WB: begin
               reg_wen_reg  <= 1'b0;
               state_reg    <= S_IDLE;
               busy_reg     <= 1'b0;
               op_ready_reg <= 1'b1;
            end
            S_FLT: begin
               fault_reg    <= 1'b0;
               state_reg    <= S_IDLE;
               busy_reg     <= 1'b0;
               op_ready_reg <= 1'b1;
            end
            default: begin
               state_reg    <= S_IDLE;
               busy_reg     <= 1'b0;
               op_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign mem.mem_req   = mem_req_reg;
   assign mem.mem_we    = mem_we_reg;
   assign mem.mem_addr  = mem_addr_reg;
   assign mem.mem_be    = mem_be_reg;
   assign mem.mem_wdata = mem_wdata_reg;
   assign op_ready      = op_ready_reg;
   assign dataW         = data_reg;
   assign rsW           = rd_reg;
   assign RegWen        = reg_wen_reg;
   assign busy          = busy_reg;
   assign fault         = fault_reg;

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Multi-cycle load/store and writeback unit that sits directly upstream of the register file's write port. It accepts one decoded memory operation per request and runs the data-memory handshake. Loads are sign/zero-extended and issued to the register file as a one-cycle write (`dataW`/`rsW`/`RegWen`); stores generate byte enables. `busy` stalls the core's PC while an operation is in flight.

## Interface
- `width`, 32: data/address width.
- `dpath`, 5: register index width.
---
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  operation present.
- `op_ready`  out  1  unit can accept (high only in IDLE).
- `op_load` / `op_store`  in  1 each  operation kind; both high counts as a fault.
- `funct3`  in  3  RV32I width/sign code.
- `addr`  in  `width`  effective byte address.
- `sdata`  in  `width`  store source (rs2 value).
- `rd`  in  `dpath`  load destination.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write.
- `mem_addr`  out  `width`  word-aligned address (`addr[1:0]` forced to 0).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  `width`  lane-replicated store data.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  `width`  read word.
- `dataW`  out  `width`  writeback data to the register file.
- `rsW`  out  `dpath`  writeback index.
- `RegWen`  out  1  writeback strobe.
- `busy`  out  1  state ≠ IDLE.
- `fault`  out  1  one-cycle pulse on misaligned or illegal operation.

## Operation
- States: IDLE, REQ, WAIT, WB, FLT.
- IDLE:
  - On `op_valid` (and `op_ready`=1), capture `op_load`, `op_store`, `funct3`, `addr`, `sdata`, `rd`.
  - Illegal or misaligned operation → FLT. This covers: load `funct3` ∈ {3,6,7}; store `funct3` ≥ 3; LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0; neither or both of `op_load`/`op_store`.
  - Otherwise → REQ.
- REQ:
  - `mem_req`=1 with address, write enable, byte enables and write data held stable until `mem_gnt`.
  - On `mem_gnt`: load → WAIT; store → IDLE.
- WAIT: on `mem_rvalid`, register the extracted value into `dataW` → WB.
- WB:
  - `RegWen`=1 only if `rd`≠0, with `rsW`=`rd`.
  - Unconditional → IDLE.
- FLT: `fault`=1, no memory request, no writeback; unconditional → IDLE.
- Load extract (`s = addr[1:0]`):
  - LB/LBU: byte `s`, sign- or zero-extended.
  - LH/LHU: halfword `addr[1]`, sign- or zero-extended.
  - LW: full word.
- Store lanes:
  - SB: `be`=4'b0001<<s, data = byte replicated ×4.
  - SH: `be`=4'b0011<<(2·`addr[1]`), data = halfword ×2.
  - SW: `be`=4'hF.
- Stray inputs: `mem_rvalid` outside WAIT and `mem_gnt` outside REQ are ignored.
- `op_valid` while not in IDLE is ignored; upstream must hold the operation until `op_ready`.

## Timing
- Reset (async assert, sync deassert by system): state=IDLE. All outputs are 0 except `op_ready`=1.
- Reset mid-operation:
  - `mem_req`, `RegWen` and `fault` drop immediately.
  - The pending transfer is abandoned; a late `rvalid` is ignored.
- Accept at edge 0 → `mem_req` high in cycle 1.
- Best-case latencies:
  - Load with `gnt` in cycle 1 and `rvalid` in cycle 2: `RegWen` in cycle 3, `busy` low in cycle 4.
  - Store with `gnt` in cycle 1: IDLE in cycle 2.
- `mem_gnt` may stay low indefinitely; REQ holds all request outputs constant.
- `dataW`/`rsW` are registered and valid only while `RegWen`=1.
- Back-to-back: the next operation is accepted in the first IDLE cycle.

## Structure
- Package `lsu_pkg`:
  - `lsu_state_e` enum.
  - `funct3` localparams `F3_B`=0, `F3_H`=1, `F3_W`=2, `F3_BU`=4, `F3_HU`=5.
- Sub-module `lsu_align`: combinational load extract, store lane/byte-enable generation, and the misalign/illegal check.
- The top level holds the FSM and the capture registers.

## Test plan
- LB, `addr`=0x1003, `mem_rdata`=0x80AA_BBCC, `rd`=5 → `dataW`=0xFFFF_FF80, `rsW`=5, `RegWen` pulse 1 cycle.
- LHU, `addr`=0x2002, `mem_rdata`=0x9ABC_1234 → `dataW`=0x0000_9ABC. LH at the same address → 0xFFFF_9ABC.
- SB, `addr`=0x11, `sdata`=0x1234_56A5 → `mem_addr`=0x10, `mem_be`=4'b0010, `mem_wdata`=0xA5A5_A5A5, `mem_we`=1, no `RegWen`.
- LW, `addr`=0x6 → `fault` for 1 cycle, `mem_req` never asserted, `busy` 1 cycle. `funct3`=3 load → same response.
- LW with `mem_gnt` held low 3 cycles and `rd`=0 → `mem_req` stable for 4 cycles, no `RegWen` after `rvalid`.
- `rst_n` pulsed low during WAIT, then `mem_rvalid`=1 → immediate IDLE, `RegWen` stays 0, `op_ready`=1.
